// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: command codes, FSM state
// type, config block size and the power-up LED timing values.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_DATA_WR = 8'h2C;

    // Number of payload bytes in one config block (t0h, t0l, t1h, t1l).
    localparam int CONF_BYTES = 4;

    localparam logic [7:0] T0H_RST = 8'h0A;
    localparam logic [7:0] T0L_RST = 8'h1E;
    localparam logic [7:0] T1H_RST = 8'h1E;
    localparam logic [7:0] T1L_RST = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONF    = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

endpackage

// File: rtl/cs_edge_sync.sv
// Brings the raw SPI chip-select into the clk_in domain with a 2-flop
// synchroniser and flags its rising edge (end of frame). All three flops
// reset to 1 so that an idle (high) chip-select produces no edge.
module cs_edge_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic cs_n_in,
    output logic cs_rise_out
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchroniser chain plus one history flop for edge detection.
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes a shift chain.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= cs_n_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge is a function of flops only, so it is glitch-free.
    assign cs_rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Byte-level command decoder behind the SPI slave receiver. The first byte
// of each chip-select frame selects config writes (four LED timing
// registers) or sequential pixel RAM writes; other commands are discarded.
// Optional feature: define CMD_ERR_CNT_EN to add a saturating error counter
// (unknown commands and bytes dropped by DATA overflow) on err_cnt_out.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              spi_cs_n_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic              ram_wr_en_out,
    output logic [ADDR_W-1:0] ram_wr_addr_out,
    output logic [7:0]        ram_wr_data_out,
    output logic [7:0]        conf_t0h_out,
    output logic [7:0]        conf_t0l_out,
    output logic [7:0]        conf_t1h_out,
    output logic [7:0]        conf_t1l_out,
    output logic              conf_done_out,
    output logic              frame_done_out,
    output logic [ADDR_W:0]   data_len_out
`ifdef CMD_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_out
`endif
);

    localparam int              CONF_IDX_W = $clog2(CONF_BYTES);
    localparam logic [CONF_IDX_W-1:0] CONF_LAST = CONF_IDX_W'(CONF_BYTES - 1);
    // Length value at which the RAM is full and further bytes are dropped.
    localparam logic [ADDR_W:0] LEN_MAX    = (ADDR_W + 1)'(RAM_DEPTH);

    logic cs_rise;

    state_e                state_q,      state_d;
    logic [CONF_IDX_W-1:0] conf_idx_q,   conf_idx_d;
    logic [ADDR_W:0]       len_q,        len_d;
    logic                  wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q,    wr_addr_d;
    logic [7:0]            wr_data_q,    wr_data_d;
    logic [7:0]            t0h_q,        t0h_d;
    logic [7:0]            t0l_q,        t0l_d;
    logic [7:0]            t1h_q,        t1h_d;
    logic [7:0]            t1l_q,        t1l_d;
    logic                  conf_done_q,  conf_done_d;
    logic                  frame_done_q, frame_done_d;
    logic [ADDR_W:0]       data_len_q,   data_len_d;

    cs_edge_sync u_cs_sync (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cs_n_in     (spi_cs_n_in),
        .cs_rise_out (cs_rise)
    );

    // Next-state and output decode; a frame end overrides any byte strobe.
    // NOTE: every variable gets a default before the branches, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        conf_idx_d   = conf_idx_q;
        len_d        = len_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        t0h_d        = t0h_q;
        t0l_d        = t0l_q;
        t1h_d        = t1h_q;
        t1l_d        = t1l_q;
        conf_done_d  = 1'b0;
        frame_done_d = 1'b0;
        data_len_d   = data_len_q;

        if (cs_rise) begin
            state_d = ST_IDLE;
            if (state_q == ST_DATA) begin
                frame_done_d = 1'b1;
                data_len_d   = len_q;
            end
        end else if (byte_rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data_in == CMD_CONF_WR) begin
                        state_d    = ST_CONF;
                        conf_idx_d = '0;
                    end else if (byte_data_in == CMD_DATA_WR) begin
                        state_d   = ST_DATA;
                        len_d     = '0;
                        wr_addr_d = '0;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_CONF: begin
                    case (conf_idx_q)
                        2'd0:    t0h_d = byte_data_in;
                        2'd1:    t0l_d = byte_data_in;
                        2'd2:    t1h_d = byte_data_in;
                        default: t1l_d = byte_data_in;
                    endcase
                    if (conf_idx_q == CONF_LAST) begin
                        conf_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        conf_idx_d = conf_idx_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    // Once full, the address holds and bytes are dropped.
                    if (len_q != LEN_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = len_q[ADDR_W-1:0];
                        wr_data_d = byte_data_in;
                        len_d     = len_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset restores every output immediately.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            conf_idx_q   <= '0;
            len_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            t0h_q        <= T0H_RST;
            t0l_q        <= T0L_RST;
            t1h_q        <= T1H_RST;
            t1l_q        <= T1L_RST;
            conf_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            conf_idx_q   <= conf_idx_d;
            len_q        <= len_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            t0h_q        <= t0h_d;
            t0l_q        <= t0l_d;
            t1h_q        <= t1h_d;
            t1l_q        <= t1l_d;
            conf_done_q  <= conf_done_d;
            frame_done_q <= frame_done_d;
            data_len_q   <= data_len_d;
        end
    end

`ifdef CMD_ERR_CNT_EN
    logic       err_inc;
    logic [7:0] err_cnt_q;

    // Error events: unknown command byte, or a byte dropped by a full RAM.
    always_comb begin
        err_inc = 1'b0;
        if (byte_rdy_in && !cs_rise) begin
            if (state_q == ST_IDLE &&
                byte_data_in != CMD_CONF_WR && byte_data_in != CMD_DATA_WR)
                err_inc = 1'b1;
            if (state_q == ST_DATA && len_q == LEN_MAX)
                err_inc = 1'b1;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            err_cnt_q <= 8'h00;
        else if (err_inc && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'h01;
    end

    assign err_cnt_out = err_cnt_q;
`endif

    assign ram_wr_en_out   = wr_en_q;
    assign ram_wr_addr_out = wr_addr_q;
    assign ram_wr_data_out = wr_data_q;
    assign conf_t0h_out    = t0h_q;
    assign conf_t0l_out    = t0l_q;
    assign conf_t1h_out    = t1h_q;
    assign conf_t1l_out    = t1l_q;
    assign conf_done_out   = conf_done_q;
    assign frame_done_out  = frame_done_q;
    assign data_len_out    = data_len_q;

endmodule
